pxs_vga_stream_gen: RTL

//   Source end of the pixel-stream chain. Generates the 23-bit VGA stream
//   {XC[22:13], YC[12:3], HS[2], VS[1], Active[0]} from free-running h/v counters.

---
 rtl/pxs_vga_stream_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/pxs_vga_stream_gen.sv
// Source of the pixel stream: free-running h/v counters encoded to {XC,YC,HS,VS,Active}.
// Latency: 1 cycle from counters to VGAStr_o / line_start / frame_start.
// No backpressure: one word per px_clk. PXS_FRAME_CNT_EN adds the frame_cnt output.
module pxs_vga_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        px_clk,
    input  logic        reset,
    output logic [22:0] VGAStr_o,
    output logic        line_start,
`ifdef PXS_FRAME_CNT_EN
    output logic        frame_start,
    output logic [15:0] frame_cnt
`else
    output logic        frame_start
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // XC/YC are 10 bits wide, so totals beyond 1024 cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("pxs_vga_stream_gen: H_TOTAL/V_TOTAL exceed 1024");
    end

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [22:0] r_vga;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_hs;
    logic        w_vs;
    logic        w_active;
    logic        w_h_wrap;
    logic        w_frame_pos;
    logic [22:0] w_word;

    always_comb begin
        w_hs        = ~SYNC_POL;
        w_vs        = ~SYNC_POL;
        if (int'(r_h_cnt) >= HS_START && int'(r_h_cnt) < HS_END) w_hs = SYNC_POL;
        if (int'(r_v_cnt) >= VS_START && int'(r_v_cnt) < VS_END) w_vs = SYNC_POL;
        w_active    = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
        w_h_wrap    = (r_h_cnt == H_LAST);
        w_frame_pos = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
        w_word      = {r_h_cnt, r_v_cnt, w_hs, w_vs, w_active};
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_vga         <= {20'd0, ~SYNC_POL, ~SYNC_POL, 1'b0};
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vga         <= w_word;
            r_line_start  <= (r_h_cnt == 10'd0);
            r_frame_start <= w_frame_pos;
            if (w_h_wrap) begin
                r_h_cnt <= 10'd0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    assign VGAStr_o    = r_vga;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef PXS_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic        r_frame_seen;

    // The first frame_start after reset opens frame 1 and is not counted.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_frame_cnt  <= 16'd0;
            r_frame_seen <= 1'b0;
        end else if (w_frame_pos) begin
            if (r_frame_seen) r_frame_cnt <= r_frame_cnt + 16'd1;
            r_frame_seen <= 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
